// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the gate BIST checker family.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of input vectors for a gate with n_in inputs.
  function automatic int nvec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable down-counter that stops at zero; used to time the settle interval.
module bist_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  assign o_zero = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && !o_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/gate_bist_checker.sv
// Exhaustive stimulus/response self-test for a single-output logic gate:
// walks every input vector, waits SETTLE cycles, compares against TRUTH.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int                          N_IN   = 1,
  parameter int                          SETTLE = 1,
  parameter logic [nvec(N_IN)-1:0]       TRUTH  = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_seen
);

  localparam int              NVEC        = nvec(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(NVEC - 1);
  localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [N_IN-1:0] r_stim;
  logic [N_IN:0]   r_err_cnt;
  logic [N_IN-1:0] r_first_fail;
  logic            r_fail_seen;
  logic            r_done;

  logic w_clear;
  logic w_load;
  logic w_dec;
  logic w_sample;
  logic w_last;
  logic w_mismatch;
  logic w_timer_zero;

  bist_settle_timer #(
    .W (CW)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_value (SETTLE_LOAD),
    .i_dec   (w_dec),
    .o_zero  (w_timer_zero)
  );

  assign w_last     = (r_stim == LAST_VEC);
  assign w_mismatch = (dut_out != TRUTH[r_stim]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_load       = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (w_timer_zero) begin
          w_state_next = CHECK;
        end else begin
          w_dec = 1'b1;
        end
      end
      CHECK: begin
        w_sample = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end else begin
          w_load       = 1'b1;
          w_state_next = WAIT;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Last-vector test comes before the increment, so stim never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stim       <= '0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_fail_seen  <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_clear) begin
      r_stim       <= '0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_fail_seen  <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_sample) begin
      if (w_mismatch) begin
        r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_fail_seen) begin
          r_first_fail <= r_stim;
          r_fail_seen  <= 1'b1;
        end
      end
      if (w_last) begin
        r_done <= 1'b1;
      end else begin
        r_stim <= r_stim + 1'b1;
      end
    end
  end

  assign stim       = r_stim;
  assign busy       = (r_state == WAIT) || (r_state == CHECK);
  assign done       = r_done;
  assign pass       = r_done && (r_err_cnt == '0);
  assign err_cnt    = r_err_cnt;
  assign first_fail = r_first_fail;
  assign fail_seen  = r_fail_seen;

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
- Hardware stimulus/response engine for the team's logic-gate library: the sequential counterpart to the combinational gates it exercises.
- Drives every input combination to a gate under test, waits a settle interval, samples the gate output and compares it against a parameterised truth table.
- Reports pass/fail, the error count and the first failing vector.
- Sits beside any not/and/or/xor gate instance as a built-in self-test block.

Parameters:
- N_IN, default 1: number of gate inputs; legal range 1..8.
- SETTLE, default 1: cycles stim is held before sampling; minimum 1.
- TRUTH, default 2'b01: expected output table, width 2**N_IN. Bit i is the expected output for stim == i. The default is the NOT-gate table.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a test run; ignored unless in IDLE or DONE.
- stim  output  N_IN  input vector driven to the gate under test.
- dut_out  input  1  output of the gate under test.
- busy  output  1  high while a run is in progress.
- done  output  1  high from the end of a run until the next start.
- pass  output  1  high when done==1 and err_cnt==0.
- err_cnt  output  N_IN+1  number of mismatching vectors in the last run.
- first_fail  output  N_IN  stim value of the first mismatch; 0 if none.
- fail_seen  output  1  high once any mismatch has occurred in the current or last run.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - stim=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, fail_seen=0, settle counter=0.
  - Reset asserted mid-run aborts the run immediately; no partial results are kept.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE or DONE, start==1 at a rising edge:
  - stim<=0, err_cnt<=0, first_fail<=0, fail_seen<=0.
  - done<=0, settle counter<=SETTLE-1, state<=WAIT.
- WAIT:
  - busy=1; stim is held.
  - If counter==0, go to CHECK; otherwise decrement the counter.
  - WAIT therefore lasts exactly SETTLE cycles.
- CHECK (one cycle):
  - dut_out is sampled at the rising edge that ends CHECK and compared with TRUTH[stim].
  - Mismatch: err_cnt<=err_cnt+1.
  - Mismatch with fail_seen==0: first_fail<=stim and fail_seen<=1.
  - stim == 2**N_IN-1 (last vector): state<=DONE, done<=1. stim holds its final value.
  - Otherwise: stim<=stim+1, counter<=SETTLE-1, state<=WAIT.
- DONE: busy=0, done=1; results are held until the next start.
- pass is combinational: done && (err_cnt==0).
- Latency: SETTLE+1 cycles per vector. done rises exactly 2**N_IN*(SETTLE+1) cycles after the edge that sampled start.
- Widths:
  - err_cnt is N_IN+1 bits, so its maximum 2**N_IN cannot overflow and no saturation is needed.
  - stim never wraps within a run; the last-vector check precedes the increment.
- Simultaneous events:
  - start while busy: ignored, and the run continues unaffected.
  - start in DONE: restarts; all results are cleared on that same edge.
- dut_out is treated as already synchronous; no synchroniser is inside the block.

Decomposition:
- Shared package gate_bist_pkg holds the state enum: IDLE=2'd0, WAIT=2'd1, CHECK=2'd2, DONE=2'd3.
- The same package holds the localparam NVEC = 2**N_IN, as a helper function.
- One natural sub-module, bist_settle_timer: a loadable down-counter with load, value and zero flag, reusable by other gate checkers.
- Comparison logic and result registers stay in the top module.

Test Plan:
- NOT gate, N_IN=1, SETTLE=1, TRUTH=2'b01, correct inverter, one start pulse -> stim sequence 0,0,1,1. done rises 4 cycles after start, with pass=1, err_cnt=0, first_fail=0.
- Same setup, but dut_out tied to 0 -> vector 0 mismatches. done rises with err_cnt=1, first_fail=0, fail_seen=1, pass=0.
- AND gate, N_IN=2, SETTLE=3, TRUTH=4'b1000, gate replaced by OR -> vectors 1 and 2 mismatch. err_cnt=2, first_fail=1, done after 16 cycles.
- Mid-run behaviour, N_IN=2:
  - start re-pulsed during WAIT of vector 1 -> ignored, and done still arrives at 16 cycles.
  - rst_n pulsed low during CHECK of vector 2 -> all outputs return to 0 asynchronously, state IDLE.
- Back-to-back runs: start in DONE after a failing run, with the DUT fixed -> err_cnt, first_fail and fail_seen clear on the start edge. The second run ends with pass=1.
- Boundary: N_IN=8, SETTLE=1, all vectors correct -> stim reaches 255 without wrapping. done rises at 512 cycles with err_cnt=0.
